// File: rtl/ldst_request_scheduler_pkg.sv
// Shared definitions for the load/store request scheduler: owner tags,
// access-size encodings, grant selector and the pipe command bundle.
package ldst_request_scheduler_pkg;

  // Owner tag stored per in-flight access; selects the response route.
  localparam logic LDST_OWNER_EXE    = 1'b0;
  localparam logic LDST_OWNER_EXCEPT = 1'b1;

  // Access size encodings carried on the ORDER fields.
  localparam logic [1:0] LDST_ORDER_BYTE = 2'b00;
  localparam logic [1:0] LDST_ORDER_HALF = 2'b01;
  localparam logic [1:0] LDST_ORDER_WORD = 2'b10;
  localparam logic [1:0] LDST_ORDER_NONE = 2'b11;

  // EXCEPT accesses are always full-word byte-enable.
  localparam logic [3:0] LDST_EXCEPT_MASK = 4'hf;

  typedef enum logic [1:0] {
    GRANT_NONE   = 2'd0,
    GRANT_EXE    = 2'd1,
    GRANT_EXCEPT = 2'd2
  } grant_e;

  typedef struct packed {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [13:0] tid;
    logic [1:0]  mmumod;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } ldst_cmd_t;

endpackage

// File: rtl/ldst_request_scheduler_owner_fifo.sv
// In-order owner tracking FIFO: one owner bit per accepted-but-unanswered
// access. The head tells which requester the next pipe response belongs to.
module ldst_owner_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             push_owner_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage write; contents are only meaningful between pointers.
  // NOTE: storage has no reset; clearing the pointers/count already empties the FIFO.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_owner_i;
  end

  // Next pointers and occupancy; push and pop together leave the count unchanged.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  // Pointer/count registers with async reset and synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ldst_request_scheduler.sv
// Arbitrates the single load/store pipe between EXE and EXCEPT with exception
// locking and anti-starvation, and routes in-order responses back to the
// requester that issued each access.
module ldst_request_scheduler
  import ldst_request_scheduler_pkg::*;
#(
  parameter  int OUTSTANDING      = 4,
  parameter  int MAX_EXCEPT_BURST = 8,
  localparam int CNT_W            = $clog2(OUTSTANDING) + 1
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  // EXE requester
  input  logic             iEXE_REQ,
  output logic             oEXE_BUSY,
  input  logic [1:0]       iEXE_ORDER,
  input  logic [3:0]       iEXE_MASK,
  input  logic             iEXE_RW,
  input  logic [13:0]      iEXE_TID,
  input  logic [1:0]       iEXE_MMUMOD,
  input  logic [31:0]      iEXE_PDT,
  input  logic [31:0]      iEXE_ADDR,
  input  logic [31:0]      iEXE_DATA,
  output logic             oEXE_REQ,
  output logic             oEXE_PAGEFAULT,
  output logic [13:0]      oEXE_MMU_FLAGS,
  output logic [31:0]      oEXE_DATA,
  // EXCEPT requester
  input  logic             iEXCEPT_REQ,
  output logic             oEXCEPT_BUSY,
  input  logic             iEXCEPT_LOCK,
  input  logic [1:0]       iEXCEPT_ORDER,
  input  logic             iEXCEPT_RW,
  input  logic [13:0]      iEXCEPT_TID,
  input  logic [1:0]       iEXCEPT_MMUMOD,
  input  logic [31:0]      iEXCEPT_PDT,
  input  logic [31:0]      iEXCEPT_ADDR,
  input  logic [31:0]      iEXCEPT_DATA,
  output logic             oEXCEPT_REQ,
  output logic [31:0]      oEXCEPT_DATA,
  // Load/store pipe
  output logic             oLDST_REQ,
  input  logic             iLDST_BUSY,
  output logic [1:0]       oLDST_ORDER,
  output logic [3:0]       oLDST_MASK,
  output logic             oLDST_RW,
  output logic [13:0]      oLDST_TID,
  output logic [1:0]       oLDST_MMUMOD,
  output logic [31:0]      oLDST_PDT,
  output logic [31:0]      oLDST_ADDR,
  output logic [31:0]      oLDST_DATA,
  input  logic             iLDST_VALID,
  input  logic             iLDST_PAGEFAULT,
  input  logic [13:0]      iLDST_MMU_FLAGS,
  input  logic [31:0]      iLDST_DATA,
  // Status
  output logic [CNT_W-1:0] oPENDING,
  output logic             oSPURIOUS
);

  localparam int BURST_W = $clog2(MAX_EXCEPT_BURST + 1);

  grant_e            grant;
  ldst_cmd_t         exe_cmd, except_cmd, ldst_cmd;
  logic              lock_q, lock_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic              spurious_q, spurious_d;
  logic              exe_accept, except_accept;
  logic              fifo_full, fifo_empty, fifo_head, fifo_push, fifo_pop;
  logic [CNT_W-1:0]  fifo_count;

  assign exe_cmd    = '{order: iEXE_ORDER, mask: iEXE_MASK, rw: iEXE_RW, tid: iEXE_TID,
                        mmumod: iEXE_MMUMOD, pdt: iEXE_PDT, addr: iEXE_ADDR, data: iEXE_DATA};
  assign except_cmd = '{order: iEXCEPT_ORDER, mask: LDST_EXCEPT_MASK, rw: iEXCEPT_RW,
                        tid: iEXCEPT_TID, mmumod: iEXCEPT_MMUMOD, pdt: iEXCEPT_PDT,
                        addr: iEXCEPT_ADDR, data: iEXCEPT_DATA};

  // Grant: lock holds the pipe for EXCEPT; otherwise EXCEPT wins unless EXE has starved too long.
  always_comb begin
    grant = GRANT_NONE;
    if (lock_q)
      grant = GRANT_EXCEPT;
    else if (iEXCEPT_REQ && !(iEXE_REQ && burst_q == BURST_W'(MAX_EXCEPT_BURST)))
      grant = GRANT_EXCEPT;
    else if (iEXE_REQ)
      grant = GRANT_EXE;
  end

  assign oEXE_BUSY     = (grant != GRANT_EXE)    || iLDST_BUSY || fifo_full;
  assign oEXCEPT_BUSY  = (grant != GRANT_EXCEPT) || iLDST_BUSY || fifo_full;
  assign exe_accept    = iEXE_REQ    && !oEXE_BUSY;
  assign except_accept = iEXCEPT_REQ && !oEXCEPT_BUSY;

  assign oLDST_REQ = ((grant == GRANT_EXE && iEXE_REQ) ||
                      (grant == GRANT_EXCEPT && iEXCEPT_REQ)) && !fifo_full;
  assign ldst_cmd  = (grant == GRANT_EXCEPT) ? except_cmd : exe_cmd;

  assign oLDST_ORDER  = ldst_cmd.order;
  assign oLDST_MASK   = ldst_cmd.mask;
  assign oLDST_RW     = ldst_cmd.rw;
  assign oLDST_TID    = ldst_cmd.tid;
  assign oLDST_MMUMOD = ldst_cmd.mmumod;
  assign oLDST_PDT    = ldst_cmd.pdt;
  assign oLDST_ADDR   = ldst_cmd.addr;
  assign oLDST_DATA   = ldst_cmd.data;

  // A response with nothing tracked is dropped: no route, no pop.
  assign fifo_push  = exe_accept || except_accept;
  assign fifo_pop   = iLDST_VALID && !fifo_empty;
  assign spurious_d = iLDST_VALID && fifo_empty;

  ldst_owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
    .clk          (iCLOCK),
    .rst_n        (inRESET),
    .clear_i      (iRESET_SYNC),
    .push_i       (fifo_push),
    .push_owner_i (except_accept ? LDST_OWNER_EXCEPT : LDST_OWNER_EXE),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign oEXE_REQ       = fifo_pop && (fifo_head == LDST_OWNER_EXE);
  assign oEXCEPT_REQ    = fifo_pop && (fifo_head == LDST_OWNER_EXCEPT);
  assign oEXE_PAGEFAULT = iLDST_PAGEFAULT;
  assign oEXE_MMU_FLAGS = iLDST_MMU_FLAGS;
  assign oEXE_DATA      = iLDST_DATA;
  assign oEXCEPT_DATA   = iLDST_DATA;
  assign oPENDING       = fifo_count;
  assign oSPURIOUS      = spurious_q;

  // Next lock and starvation-burst state.
  always_comb begin
    lock_d  = lock_q;
    burst_d = burst_q;
    if (except_accept && iEXCEPT_LOCK) lock_d = 1'b1;
    else if (!iEXCEPT_LOCK)            lock_d = 1'b0;
    if (exe_accept || !iEXE_REQ)
      burst_d = '0;
    else if (except_accept && burst_q != BURST_W'(MAX_EXCEPT_BURST))
      burst_d = burst_q + BURST_W'(1);
  end

  // Lock, burst and spurious-pulse registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      lock_q     <= 1'b0;
      burst_q    <= '0;
      spurious_q <= 1'b0;
    end else if (iRESET_SYNC) begin
      lock_q     <= 1'b0;
      burst_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      burst_q    <= burst_d;
      spurious_q <= spurious_d;
    end
  end

endmodule

// File: tb/tb_ldst_request_scheduler.sv
// Scoreboard bench for ldst_request_scheduler: directed scenarios followed by
// random traffic, checked against a queue-based behavioural model.
module tb_ldst_request_scheduler;
  import ldst_request_scheduler_pkg::*;

  localparam int OUT = 4;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        inRESET, iRESET_SYNC;
  logic        iEXE_REQ, iEXE_RW;
  logic [1:0]  iEXE_ORDER, iEXE_MMUMOD;
  logic [3:0]  iEXE_MASK;
  logic [13:0] iEXE_TID;
  logic [31:0] iEXE_PDT, iEXE_ADDR, iEXE_DATA;
  logic        iEXCEPT_REQ, iEXCEPT_LOCK, iEXCEPT_RW;
  logic [1:0]  iEXCEPT_ORDER, iEXCEPT_MMUMOD;
  logic [13:0] iEXCEPT_TID;
  logic [31:0] iEXCEPT_PDT, iEXCEPT_ADDR, iEXCEPT_DATA;
  logic        iLDST_BUSY, iLDST_VALID, iLDST_PAGEFAULT;
  logic [13:0] iLDST_MMU_FLAGS;
  logic [31:0] iLDST_DATA;

  logic        oEXE_BUSY, oEXE_REQ, oEXE_PAGEFAULT;
  logic [13:0] oEXE_MMU_FLAGS;
  logic [31:0] oEXE_DATA;
  logic        oEXCEPT_BUSY, oEXCEPT_REQ;
  logic [31:0] oEXCEPT_DATA;
  logic        oLDST_REQ, oLDST_RW;
  logic [1:0]  oLDST_ORDER, oLDST_MMUMOD;
  logic [3:0]  oLDST_MASK;
  logic [13:0] oLDST_TID;
  logic [31:0] oLDST_PDT, oLDST_ADDR, oLDST_DATA;
  logic [2:0]  oPENDING;
  logic        oSPURIOUS;

  ldst_request_scheduler #(.OUTSTANDING(OUT), .MAX_EXCEPT_BURST(MAXB)) dut (
    .iCLOCK(clk), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iEXE_REQ(iEXE_REQ), .oEXE_BUSY(oEXE_BUSY), .iEXE_ORDER(iEXE_ORDER),
    .iEXE_MASK(iEXE_MASK), .iEXE_RW(iEXE_RW), .iEXE_TID(iEXE_TID),
    .iEXE_MMUMOD(iEXE_MMUMOD), .iEXE_PDT(iEXE_PDT), .iEXE_ADDR(iEXE_ADDR),
    .iEXE_DATA(iEXE_DATA), .oEXE_REQ(oEXE_REQ), .oEXE_PAGEFAULT(oEXE_PAGEFAULT),
    .oEXE_MMU_FLAGS(oEXE_MMU_FLAGS), .oEXE_DATA(oEXE_DATA),
    .iEXCEPT_REQ(iEXCEPT_REQ), .oEXCEPT_BUSY(oEXCEPT_BUSY), .iEXCEPT_LOCK(iEXCEPT_LOCK),
    .iEXCEPT_ORDER(iEXCEPT_ORDER), .iEXCEPT_RW(iEXCEPT_RW), .iEXCEPT_TID(iEXCEPT_TID),
    .iEXCEPT_MMUMOD(iEXCEPT_MMUMOD), .iEXCEPT_PDT(iEXCEPT_PDT),
    .iEXCEPT_ADDR(iEXCEPT_ADDR), .iEXCEPT_DATA(iEXCEPT_DATA),
    .oEXCEPT_REQ(oEXCEPT_REQ), .oEXCEPT_DATA(oEXCEPT_DATA),
    .oLDST_REQ(oLDST_REQ), .iLDST_BUSY(iLDST_BUSY), .oLDST_ORDER(oLDST_ORDER),
    .oLDST_MASK(oLDST_MASK), .oLDST_RW(oLDST_RW), .oLDST_TID(oLDST_TID),
    .oLDST_MMUMOD(oLDST_MMUMOD), .oLDST_PDT(oLDST_PDT), .oLDST_ADDR(oLDST_ADDR),
    .oLDST_DATA(oLDST_DATA), .iLDST_VALID(iLDST_VALID), .iLDST_PAGEFAULT(iLDST_PAGEFAULT),
    .iLDST_MMU_FLAGS(iLDST_MMU_FLAGS), .iLDST_DATA(iLDST_DATA),
    .oPENDING(oPENDING), .oSPURIOUS(oSPURIOUS)
  );

  typedef struct {
    bit          owner;  // 0 = EXE, 1 = EXCEPT
    logic [31:0] data;
    bit          fault;
  } resp_t;

  // Behavioural model: owners of in-flight accesses in issue order.
  bit    inflight_q[$];
  resp_t exp_q[$];
  bit    lock_m;
  int    burst_m;
  bit    spur_pend;
  int    total = 0;
  int    bad   = 0;
  bit    last_eacc, last_xacc;
  resp_t mon_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every routed response must match the oldest expected one.
  always @(negedge clk) begin
    if (inRESET && (oEXE_REQ || oEXCEPT_REQ)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got exe=%0b except=%0b expected none", oEXE_REQ, oEXCEPT_REQ);
      end else begin
        mon_r = exp_q.pop_front();
        check("resp_route", {oEXE_REQ, oEXCEPT_REQ}, mon_r.owner ? 64'h1 : 64'h2);
        check("resp_data", mon_r.owner ? oEXCEPT_DATA : oEXE_DATA, mon_r.data);
        if (!mon_r.owner) check("resp_fault", oEXE_PAGEFAULT, mon_r.fault);
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic step(input bit exe, input bit exc, input bit lk, input bit busy,
                      input bit valid, input logic [31:0] rdata, input logic [31:0] eaddr,
                      input bit sync);
    bit full, exp_ebusy, exp_xbusy, exp_lreq, eacc, xacc;
    int g;  // 0 none, 1 EXE, 2 EXCEPT
    iEXE_REQ = exe; iEXCEPT_REQ = exc; iEXCEPT_LOCK = lk; iLDST_BUSY = busy;
    iRESET_SYNC = sync;
    iEXE_ADDR = eaddr; iEXE_DATA = $urandom; iEXE_MASK = 4'($urandom);
    iEXE_ORDER = 2'($urandom); iEXE_RW = 1'($urandom); iEXE_TID = 14'($urandom);
    iEXE_MMUMOD = 2'($urandom); iEXE_PDT = $urandom;
    iEXCEPT_ADDR = $urandom; iEXCEPT_DATA = $urandom; iEXCEPT_ORDER = 2'($urandom);
    iEXCEPT_RW = 1'($urandom); iEXCEPT_TID = 14'($urandom);
    iEXCEPT_MMUMOD = 2'($urandom); iEXCEPT_PDT = $urandom;
    iLDST_VALID = valid; iLDST_DATA = rdata; iLDST_PAGEFAULT = 1'($urandom);
    iLDST_MMU_FLAGS = 14'($urandom);
    if (valid && inflight_q.size() > 0)
      exp_q.push_back('{owner: inflight_q[0], data: rdata, fault: iLDST_PAGEFAULT});
    @(negedge clk);
    full = (inflight_q.size() == OUT);
    if (lock_m)                               g = 2;
    else if (exc && !(exe && burst_m == MAXB)) g = 2;
    else if (exe)                             g = 1;
    else                                      g = 0;
    exp_ebusy = (g != 1) || busy || full;
    exp_xbusy = (g != 2) || busy || full;
    exp_lreq  = ((g == 1 && exe) || (g == 2 && exc)) && !full;
    check("exe_busy", oEXE_BUSY, exp_ebusy);
    check("except_busy", oEXCEPT_BUSY, exp_xbusy);
    check("ldst_req", oLDST_REQ, exp_lreq);
    check("pending", oPENDING, inflight_q.size());
    check("spurious", oSPURIOUS, spur_pend);
    check("resp_any", oEXE_REQ | oEXCEPT_REQ, valid && inflight_q.size() > 0);
    if (exp_lreq) begin
      check("ldst_addr", oLDST_ADDR, (g == 2) ? iEXCEPT_ADDR : iEXE_ADDR);
      check("ldst_mask", oLDST_MASK, (g == 2) ? 4'hf : iEXE_MASK);
      check("ldst_data", oLDST_DATA, (g == 2) ? iEXCEPT_DATA : iEXE_DATA);
    end
    eacc = exe && !exp_ebusy;
    xacc = exc && !exp_xbusy;
    last_eacc = eacc;
    last_xacc = xacc;
    if (sync) begin
      inflight_q.delete();
      lock_m = 0; burst_m = 0; spur_pend = 0;
    end else begin
      spur_pend = valid && inflight_q.size() == 0;
      if (valid && inflight_q.size() > 0) void'(inflight_q.pop_front());
      if (eacc) inflight_q.push_back(1'b0);
      if (xacc) inflight_q.push_back(1'b1);
      if (xacc && lk)  lock_m = 1;
      else if (!lk)    lock_m = 0;
      if (eacc || !exe)               burst_m = 0;
      else if (xacc && burst_m < MAXB) burst_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && inflight_q.size() > 0; i++)
      step(0, 0, 0, 0, 1, $urandom, $urandom, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);  // let any spurious pulse expectation settle
  endtask

  task automatic async_reset();
    inRESET = 1'b0;
    iEXE_REQ = 0; iEXCEPT_REQ = 0; iEXCEPT_LOCK = 0; iLDST_VALID = 0; iRESET_SYNC = 0;
    inflight_q.delete();
    lock_m = 0; burst_m = 0; spur_pend = 0;
    @(negedge clk);
    check("rst_ldst_req", oLDST_REQ, 0);
    check("rst_exe_busy", oEXE_BUSY, 1);
    check("rst_except_busy", oEXCEPT_BUSY, 1);
    check("rst_pending", oPENDING, 0);
    check("rst_spurious", oSPURIOUS, 0);
    check("rst_resp", {oEXE_REQ, oEXCEPT_REQ}, 0);
    @(posedge clk);
    #1 inRESET = 1'b1;
  endtask

  initial begin
    int n;
    iLDST_BUSY = 0; iLDST_DATA = 0; iLDST_PAGEFAULT = 0; iLDST_MMU_FLAGS = 0;
    lock_m = 0; burst_m = 0; spur_pend = 0;
    #1;
    async_reset();

    // 1: three EXE reads, then three responses
    n = 0;
    step(1, 0, 0, 0, 0, 0, 32'h100, 0); n += int'(last_eacc);
    step(1, 0, 0, 0, 0, 0, 32'h104, 0); n += int'(last_eacc);
    step(1, 0, 0, 0, 0, 0, 32'h108, 0); n += int'(last_eacc);
    check("t1_accepts", n, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'h1000 + i, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_pending_end", oPENDING, 0);

    // 2: anti-starvation; 8 EXCEPT grants, then EXE
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 0, inflight_q.size() > 0, $urandom, 32'h200 + i, 0);
      check("t2_grant", {last_eacc, last_xacc}, (i < 8) ? 64'h1 : 64'h2);
    end
    step(1, 1, 0, 0, 1, $urandom, 32'h300, 0);
    check("t2_after_reset_burst", {last_eacc, last_xacc}, 64'h1);
    drain();

    // 3: lock starves EXE for 20 accesses, then releases within 2 cycles
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1, 0, inflight_q.size() > 0, $urandom, $urandom, 0);
      n += int'(last_eacc);
    end
    check("t3_exe_starved", n, 0);
    step(1, 0, 0, 0, 1, $urandom, $urandom, 0); n = int'(last_eacc);
    step(1, 0, 0, 0, 1, $urandom, $urandom, 0); n += int'(last_eacc);
    check("t3_exe_after_unlock", n, 1);
    drain();

    // 4: full blocks the 5th access even when a response pops the same cycle
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0, 32'h400 + 4 * i, 0);
      n += int'(last_eacc);
    end
    check("t4_four_accepted", n, 4);
    step(1, 0, 0, 0, 1, 32'h44, 32'h414, 0);
    check("t4_not_same_cycle", last_eacc, 0);
    step(1, 0, 0, 0, 0, 0, 32'h414, 0);
    check("t4_next_cycle", last_eacc, 1);
    drain();

    // 5: interleaved owners get their own responses
    step(1, 0, 0, 0, 0, 0, 32'h500, 0);
    step(0, 1, 0, 0, 0, 0, 32'h504, 0);
    step(1, 0, 0, 0, 0, 0, 32'h508, 0);
    step(0, 0, 0, 0, 1, 32'hA, 0, 0);
    step(0, 0, 0, 0, 1, 32'hB, 0, 0);
    step(0, 0, 0, 0, 1, 32'hC, 0, 0);
    drain();

    // 6: async reset forgets in-flight accesses; later VALID is spurious
    step(1, 0, 0, 0, 0, 0, 32'h600, 0);
    step(1, 0, 0, 0, 0, 0, 32'h604, 0);
    async_reset();
    step(0, 0, 0, 0, 1, 32'hDEAD, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // 6b: synchronous clear behaves the same
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'hBEEF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 2,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
           $urandom_range(0, 99) == 0);
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
